// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU control codes, multiply opcode and sequencer state encoding
package alu_sequencer_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] MUL_OP  = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] MUL_LAST_CNT = 5'd31;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues single ALU ops or a 32-cycle shift-add multiply through an external shared ALU
module alu_sequencer #(
    parameter logic [2:0] MUL_OP = alu_sequencer_pkg::MUL_OP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        busy,
    output logic [31:0] alu_src_a,
    output logic [31:0] alu_src_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    import alu_sequencer_pkg::*;

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
    logic [31:0] acc_next;
    logic        handshake;

    // Readiness is withheld while reset is asserted so every output reads 0 during reset.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign handshake = req_valid && req_ready;
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    assign acc_next  = mplier[0] ? alu_result : acc;

    always_comb begin
        alu_src_a   = 32'd0;
        alu_src_b   = 32'd0;
        alu_control = ALU_ADD;
        case (state)
            ST_EXEC: begin
                alu_src_a   = a_q;
                alu_src_b   = b_q;
                alu_control = op_q;
            end
            ST_MUL: begin
                alu_src_a   = acc;
                alu_src_b   = mcand;
                alu_control = ALU_ADD;
            end
            default: begin
                alu_src_a   = 32'd0;
                alu_src_b   = 32'd0;
                alu_control = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            acc        <= 32'd0;
            mcand      <= 32'd0;
            mplier     <= 32'd0;
            cnt        <= 5'd0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        if (req_op == MUL_OP) begin
                            acc    <= 32'd0;
                            mcand  <= req_a;
                            mplier <= req_b;
                            cnt    <= 5'd0;
                            state  <= ST_MUL;
                        end else begin
                            state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= ST_DONE;
                end
                ST_MUL: begin
                    // Fixed 32 iterations; no early exit when the multiplier runs out of ones.
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == MUL_LAST_CNT) begin
                        rsp_result <= acc_next;
                        rsp_zero   <= (acc_next == 32'd0);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with a behavioural ALU and result model
module tb_alu_sequencer;

    import alu_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        busy;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;

    int checks;
    int failures;

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU living outside the sequencer; unknown codes return 0.
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            3'b000: alu_result = alu_src_a + alu_src_b;
            3'b001: alu_result = alu_src_a - alu_src_b;
            3'b010: alu_result = alu_src_a & alu_src_b;
            3'b011: alu_result = alu_src_a | alu_src_b;
            3'b101: alu_result = ($signed(alu_src_a) < $signed(alu_src_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        if (op == MUL_OP) begin
            prod = {32'd0, a} * {32'd0, b};
            return prod[31:0];
        end
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        int          wait_n;
        int          lat;
        logic [31:0] exp;
        logic [31:0] held;
        exp = model(op, a, b);
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("idle_ready", 32'(req_ready), 1);
        check_eq("idle_alu_a", alu_src_a | alu_src_b, 0);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_a     = $urandom;
        req_b     = $urandom;
        check_eq("busy_in_flight", 32'(busy), 1);
        check_eq("ready_in_flight", 32'(req_ready), 0);
        if (op == MUL_OP) begin
            check_eq("mul_first_alu_a", alu_src_a, 0);
            check_eq("mul_first_alu_b", alu_src_b, a);
            check_eq("mul_first_ctl", 32'(alu_control), 0);
        end else begin
            check_eq("exec_alu_a", alu_src_a, a);
            check_eq("exec_alu_b", alu_src_b, b);
            check_eq("exec_ctl", 32'(alu_control), 32'(op));
        end
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat + 1, (op == MUL_OP) ? 33 : 2);
        check_eq("result", rsp_result, exp);
        check_eq("zero", 32'(rsp_zero), 32'(exp == 32'd0));
        check_eq("done_alu_ports", alu_src_a | alu_src_b | 32'(alu_control), 0);
        held = rsp_result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(rsp_valid), 1);
            check_eq("stall_result", rsp_result, held);
            check_eq("stall_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("back_to_idle", 32'(req_ready), 1);
        check_eq("valid_dropped", 32'(rsp_valid), 0);
    endtask

    task automatic run_back_to_back();
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exp_q[$];
        int          idx;
        int          cyc;
        int          last_acc;
        int          rsp_cnt;
        logic [31:0] e;
        ops[0] = 3'b000; ops[1] = MUL_OP; ops[2] = 3'b001; ops[3] = 3'b101;
        for (int i = 0; i < 4; i++) begin
            as[i] = $urandom;
            bs[i] = $urandom;
        end
        idx = 0; cyc = 0; last_acc = -10; rsp_cnt = 0;
        rsp_ready = 1'b1;
        while ((idx < 4 || exp_q.size() != 0) && cyc < 300) begin
            if (rsp_valid) begin
                check_eq("b2b_rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("b2b_result", rsp_result, e);
                    rsp_cnt++;
                end
            end
            if (idx < 4) begin
                req_valid = 1'b1;
                req_op    = ops[idx];
                req_a     = as[idx];
                req_b     = bs[idx];
                if (req_ready) begin
                    if (idx > 0) check_eq("b2b_interval_ok", 32'(cyc - last_acc >= 3), 1);
                    exp_q.push_back(model(ops[idx], as[idx], bs[idx]));
                    last_acc = cyc;
                    idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_eq("b2b_rsp_count", rsp_cnt, 4);
    endtask

    task automatic run_reset_mid_mul();
        bit saw_valid;
        run_op(3'b011, 32'h00F0_0000, 32'h0000_000F, 0);
        req_valid = 1'b1;
        req_op    = MUL_OP;
        req_a     = 32'h0001_0001;
        req_b     = 32'h0000_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_result", rsp_result, 0);
        check_eq("rst_rsp_zero", 32'(rsp_zero), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_alu_a", alu_src_a, 0);
        check_eq("rst_alu_b", alu_src_b, 0);
        check_eq("rst_alu_ctl", 32'(alu_control), 0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(req_ready), 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        check_eq("no_rsp_after_rst", 32'(saw_valid), 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        #3;
        check_eq("reset_rsp_valid", 32'(rsp_valid), 0);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_result", rsp_result, 0);
        check_eq("reset_alu", alu_src_a | alu_src_b | 32'(alu_control), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("ready_after_reset", 32'(req_ready), 1);
        @(negedge clk);

        run_op(3'b000, 32'd5, 32'd7, 0);
        run_op(3'b001, 32'h1234, 32'h1234, 0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(MUL_OP, 32'h0001_0001, 32'h0001_0001, 0);
        run_op(MUL_OP, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(MUL_OP, 32'h8000_0000, 32'd2, 1);
        run_op(3'b100, 32'h55, 32'hAA, 0);
        run_op(3'b111, 32'h55, 32'hAA, 0);
        run_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);

        for (int n = 0; n < 24; n++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        run_back_to_back();
        @(negedge clk);
        run_reset_mid_mul();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_OP, default 3'b110, is the request opcode that selects the iterative multiply.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  sequencer accepts an operation this cycle.
REQ-006 req_op  input  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 101 slt) or MUL_OP.
REQ-007 req_a, req_b  input  32 each  operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes the result.
REQ-010 rsp_result  output  32  operation result.
REQ-011 rsp_zero  output  1  set when rsp_result equals 0.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 alu_src_a, alu_src_b  output  32 each; alu_control  output  3: drive the shared ALU.
REQ-014 alu_result  input  32; alu_zero  input  1: returned by the shared ALU.

Function
REQ-015 States: IDLE, EXEC, MUL, DONE; req_ready = (state == IDLE).
REQ-016 Handshake fires when req_valid && req_ready; req_op, req_a and req_b are latched on that edge.
REQ-017 IDLE -> EXEC on a handshake with req_op != MUL_OP; IDLE -> MUL on a handshake with req_op == MUL_OP; otherwise the FSM holds IDLE.
REQ-018 In EXEC the block drives the latched operands and op to the ALU, captures alu_result and alu_zero into rsp_result and rsp_zero, and moves to DONE; it has exactly 1 EXEC cycle.
REQ-019 Unimplemented codes (100, 111 when MUL_OP differs) pass through EXEC unchanged and yield the ALU's 0 result with rsp_zero = 1.
REQ-020 MUL setup on handshake: acc = 0, mcand = req_a, mplier = req_b, cnt = 0.
REQ-021 Each MUL cycle drives alu_src_a = acc, alu_src_b = mcand and alu_control = 000.
REQ-022 Each MUL cycle updates acc <= alu_result if mplier[0] (else acc holds), mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
REQ-023 MUL runs exactly 32 cycles with no early exit; after the cycle with cnt == 31, rsp_result <= final acc, rsp_zero <= (final acc == 0), and the FSM moves to DONE.
REQ-024 MUL produces the low 32 bits of the unsigned product (identical to the signed low word); overflow is discarded.
REQ-025 In DONE rsp_valid = 1, with rsp_result and rsp_zero held stable until rsp_ready; DONE -> IDLE on rsp_ready.
REQ-026 A new request is never accepted in the DONE cycle; minimum issue interval is 3 cycles.
REQ-027 Latency from the handshake edge T: rsp_valid rises at T+2 for single ops and at T+33 for MUL.
REQ-028 In IDLE and DONE the ALU ports are driven with alu_src_a = 0, alu_src_b = 0 and alu_control = 000.
REQ-029 req_* changes after the handshake have no effect on an operation in flight.

Reset
REQ-030 Reset asserted at any time forces state IDLE, rsp_valid 0, rsp_result 0, rsp_zero 0, busy 0, acc/mcand/mplier/cnt 0 and ALU ports 0.
REQ-031 An operation interrupted by reset is discarded and produces no response.
REQ-032 req_ready is 1 in the first cycle after reset deasserts.

Structure
REQ-033 A shared package holds the ALU control code constants (ADD, SUB, AND, OR, SLT), MUL_OP, and the state encoding.
REQ-034 The design is one module with no sub-modules; the ALU is instantiated outside and connected through the alu_* ports.

Verification
REQ-035 Add: op 000, a = 5, b = 7, rsp_ready = 1 -> rsp_valid at T+2 with rsp_result 12 and rsp_zero 0.
REQ-036 Sub equal: op 001, a = b = 0x1234 -> rsp_result 0, rsp_zero 1; slt with a = 0xFFFFFFFF, b = 1 -> rsp_result 1.
REQ-037 Multiply: MUL_OP, a = 0x10001, b = 0x10001 -> rsp_valid at T+33 with rsp_result 0x00020001; a = 0xFFFFFFFF, b = 2 -> rsp_result 0xFFFFFFFE.
REQ-038 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and rsp_result is stable, req_ready stays 0, and IDLE is reached the cycle after rsp_ready = 1.
REQ-039 Reset mid-MUL: reset asserted at cycle 10 of a MUL -> all outputs 0 immediately, with no rsp_valid afterwards, and req_ready = 1 after release.
REQ-040 Back-to-back traffic: req_valid held high with 4 queued ops -> each is accepted only in IDLE, and responses come out in order with correct values.
